pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage.sv | 44 ++++
 rtl/pipe_reg_chain.sv | 138 +++++++++++++
 tb/tb_pipe_reg_chain.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
//==============================================================================
// Module  : pipe_pkg
// Brief   : Shared defaults and sizing helper for the pipe_reg_chain block.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_pkg;

  localparam int c_default_width = 32;
  localparam int c_default_depth = 5;

  // Bits needed to represent an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage.sv
//==============================================================================
// Module  : pipe_stage
// Brief   : One pipeline slot: payload + valid register with load enable.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Bubbles update only the valid bit, so payload bits never toggle needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clr) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= d_valid;
      if (d_valid) begin
        r_data <= d_data;
      end
    end
  end

  assign q_valid = r_valid;
  assign q_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
//==============================================================================
// Module  : pipe_reg_chain
// Brief   : Elastic DEPTH-stage register chain with compaction, flush and
//           occupancy count. Define PIPE_PARITY_EN for per-stage even parity.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int DEPTH = c_default_depth
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  input  logic                        par_inj,
  output logic                        par_err
);

  localparam int c_cw = cnt_width(DEPTH);
`ifdef PIPE_PARITY_EN
  localparam int c_sw = WIDTH + 1;
`else
  localparam int c_sw = WIDTH;
`endif
  localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_one_cnt   = c_cw'(1);

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [c_sw-1:0]  w_q [DEPTH];
  logic [c_sw-1:0]  w_in_word;
  logic             w_go;
  logic             w_fire_in;
  logic             w_fire_out;
  logic [c_cw-1:0]  r_count;

  assign w_go = out_ready & ~flush;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic            w_d_valid;
      logic [c_sw-1:0] w_d_data;

      // The advance recursion unrolls to: a stage moves when the tail drains
      // or any downstream slot is empty, so no bit depends on its own vector.
      if (k == DEPTH - 1) begin : g_tail
        assign w_adv[k] = w_vld[k] & w_go;
      end else begin : g_body
        assign w_adv[k] = w_vld[k] & (w_go | ~(&w_vld[DEPTH-1:k+1]));
      end

      if (k == 0) begin : g_head_src
        assign w_d_valid = in_valid;
        assign w_d_data  = w_in_word;
      end else begin : g_prev_src
        assign w_d_valid = w_vld[k-1];
        assign w_d_data  = w_q[k-1];
      end

      assign w_load[k] = (~w_vld[k] | w_adv[k]) & ~flush;

      pipe_stage #(
        .W(c_sw)
      ) u_stage (
        .clk    (CLK),
        .rst    (RESET),
        .clr    (flush),
        .load   (w_load[k]),
        .d_valid(w_d_valid),
        .d_data (w_d_data),
        .q_valid(w_vld[k]),
        .q_data (w_q[k])
      );
    end
  endgenerate

  assign in_ready   = (~w_vld[0] | w_adv[0]) & ~flush;
  assign out_valid  = w_vld[DEPTH-1] & ~flush;
  assign out_data   = w_q[DEPTH-1][WIDTH-1:0];
  assign w_fire_in  = in_valid & in_ready;
  assign w_fire_out = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_fire_in & ~w_fire_out) begin
      r_count <= r_count + c_one_cnt;
    end else if (~w_fire_in & w_fire_out) begin
      r_count <= r_count - c_one_cnt;
    end
  end

  assign count = r_count;
  assign full  = (r_count == c_depth_cnt);
  assign empty = (r_count == '0);

`ifdef PIPE_PARITY_EN
  logic r_par_err;
  logic w_par_bad;

  assign w_in_word = {(^in_data) ^ par_inj, in_data};
  assign w_par_bad = ^w_q[DEPTH-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_par_err <= 1'b0;
    end else if (w_fire_out & w_par_bad) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  logic w_unused_par_inj;

  assign w_in_word        = in_data;
  assign w_unused_par_inj = par_inj;
  assign par_err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
//==============================================================================
// Module  : tb_pipe_reg_chain
// Brief   : Directed self-checking bench for pipe_reg_chain (DEPTH=5).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_reg_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;

  logic             CLK;
  logic             RESET;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             par_inj;
  logic             par_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PIPE_PARITY_EN
  localparam logic c_par_exp = 1'b1;
`else
  localparam logic c_par_exp = 1'b0;
`endif

  pipe_reg_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .par_inj  (par_inj),
    .par_err  (par_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] sb[$];
  int          m_cnt;
  logic        fi;
  logic        fo;
  logic [31:0] exp_word;

  initial begin
    RESET = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; par_inj = 1'b0;
    step(); step();
    RESET = 1'b0;
    #1;
    check_eq("rst_count",     32'(count),     32'd0);
    check_eq("rst_empty",     32'(empty),     32'd1);
    check_eq("rst_full",      32'(full),      32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  out_data,       32'd0);
    check_eq("rst_par_err",   32'(par_err),   32'd0);

    // Stream 1..8, out_ready high: item n appears after edge n+3.
    in_valid = 1'b1; in_data = 32'd1; out_ready = 1'b1;
    for (int e = 0; e < 13; e++) begin
      step();
      if (e < 7) in_data = 32'(e + 2);
      else       in_valid = 1'b0;
      #1;
      if (e >= 4 && e < 12) begin
        check_eq("stream_valid", 32'(out_valid), 32'd1);
        check_eq("stream_data",  out_data,       32'(e - 3));
      end else begin
        check_eq("stream_idle",  32'(out_valid), 32'd0);
      end
      if (e == 3) check_eq("stream_cnt4", 32'(count), 32'd4);
    end
    check_eq("stream_end_cnt", 32'(count), 32'd0);

    // Fill with a blocked sink, then release.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      #1;
      check_eq("fill_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_data = 32'd6;
    #1;
    check_eq("fill_full",     32'(full),     32'd1);
    check_eq("fill_in_ready0", 32'(in_ready), 32'd0);
    check_eq("fill_count",    32'(count),    32'd5);
    check_eq("fill_head",     out_data,      32'd1);
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("release_count", 32'(count), 32'd5);
    for (int i = 2; i <= 6; i++) begin
      check_eq("drain_valid", 32'(out_valid), 32'd1);
      check_eq("drain_data",  out_data,       32'(i));
      step();
    end
    check_eq("drain_empty", 32'(empty), 32'd1);

    // Flush with three in flight and a request pending.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h11 * 32'(i + 1);
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b1;
    #1;
    check_eq("flush_pre_count", 32'(count),     32'd3);
    check_eq("flush_in_ready",  32'(in_ready),  32'd0);
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("flush_count", 32'(count),     32'd0);
    check_eq("flush_empty", 32'(empty),     32'd1);
    check_eq("flush_ovld",  32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check_eq("post_flush_valid", 32'(out_valid), 32'd1);
    check_eq("post_flush_data",  out_data,       32'h55);
    step();
    check_eq("post_flush_empty", 32'(empty), 32'd1);

    // Reset mid-flight with four held.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 9);
      step();
    end
    in_valid = 1'b0;
    #1;
    check_eq("rst4_pre_count", 32'(count), 32'd4);
    RESET = 1'b1; in_valid = 1'b1;
    step();
    RESET = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rst4_count",    32'(count),    32'd0);
    check_eq("rst4_par_err",  32'(par_err),  32'd0);
    check_eq("rst4_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst4_empty",    32'(empty),    32'd1);

    // Parity injection on 0xA5A5A5A5 (even popcount, so injection is an error).
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5A5A5; par_inj = 1'b1;
    step();
    in_valid = 1'b0; par_inj = 1'b0;
    repeat (4) step();
    check_eq("par_out_valid", 32'(out_valid), 32'd1);
    check_eq("par_out_data",  out_data,       32'hA5A5A5A5);
    check_eq("par_before",    32'(par_err),   32'd0);
    step();
    check_eq("par_after", 32'(par_err), 32'(c_par_exp));
    repeat (3) step();
    check_eq("par_sticky", 32'(par_err), 32'(c_par_exp));
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    #1;
    check_eq("par_cleared", 32'(par_err), 32'd0);

    // Random handshakes against a queue scoreboard and occupancy model.
    m_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_eq("rnd_count",    32'(count),    32'(m_cnt));
      check_eq("rnd_in_ready", 32'(in_ready), 32'((m_cnt < DEPTH) || out_ready));
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      if (fo) begin
        if (sb.size() == 0) begin
          check_eq("rnd_spurious", 32'(out_valid), 32'd0);
        end else begin
          exp_word = sb.pop_front();
          check_eq("rnd_order", out_data, exp_word);
        end
      end
      if (fi) sb.push_back(in_data);
      m_cnt = m_cnt + int'(fi) - int'(fo);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
